axi_ar_arbiter: RTL

AXI_AR_ARBITER -- requirements
Module: axi_ar_arbiter

---
 rtl/axi_ar_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/axi_ar_arbiter.sv
// axi_ar_arbiter
//   Arbitrates N_REQ read requesters onto a single AXI4 AR channel.
//   Each requester owns a one-deep pending slot. An IDLE/ISSUE FSM picks a
//   winner (round-robin or fixed priority), holds the AR beat stable until
//   arready, then returns to IDLE for one bubble cycle.
// Ports:
//   clock, reset              - rising-edge clock, synchronous active-high reset
//   req_valid / req_ready     - per-requester strobe / slot free (N_REQ bits)
//   req_addr/len/size/burst   - per-requester packed request fields
//   arvalid, arready, arid,
//   araddr, arlen, arsize,
//   arburst                   - AXI4 AR channel (arid = winner index + 1)
//   busy                      - any slot pending or arvalid high
module axi_ar_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned RR_MODE = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*8-1:0]      req_len,
  input  logic [N_REQ*3-1:0]      req_size,
  input  logic [N_REQ*2-1:0]      req_burst,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ID_W-1:0]         arid,
  output logic [ADDR_W-1:0]       araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    busy
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [IDX_W-1:0]  winner_q, winner_d;

  logic [ADDR_W-1:0] slot_addr_q  [N_REQ];
  logic [ADDR_W-1:0] slot_addr_d  [N_REQ];
  logic [7:0]        slot_len_q   [N_REQ];
  logic [7:0]        slot_len_d   [N_REQ];
  logic [2:0]        slot_size_q  [N_REQ];
  logic [2:0]        slot_size_d  [N_REQ];
  logic [1:0]        slot_burst_q [N_REQ];
  logic [1:0]        slot_burst_d [N_REQ];

  logic              arvalid_q, arvalid_d;
  logic [ID_W-1:0]   arid_q, arid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [2:0]        arsize_q, arsize_d;
  logic [1:0]        arburst_q, arburst_d;

  int unsigned       scan_start;
  logic [IDX_W-1:0]  scan_idx;
  logic [IDX_W-1:0]  win_idx;
  logic              win_found;

  // Winner search: scan starts one past the last grant in round-robin mode,
  // at index 0 in fixed-priority mode; first pending slot encountered wins.
  always_comb begin
    scan_start = (RR_MODE != 0) ? (32'(last_grant_q) + 32'd1) : 32'd0;
    scan_idx   = '0;
    win_idx    = '0;
    win_found  = 1'b0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      scan_idx = IDX_W'((scan_start + off) % N_REQ);
      if (!win_found && pending_q[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    slot_addr_d  = slot_addr_q;
    slot_len_d   = slot_len_q;
    slot_size_d  = slot_size_q;
    slot_burst_d = slot_burst_q;
    arvalid_d    = arvalid_q;
    arid_d       = arid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;

    // A granted slot is still pending, so capture never collides with the
    // handshake clear below.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && !pending_q[i]) begin
        pending_d[i]    = 1'b1;
        slot_addr_d[i]  = req_addr[i*ADDR_W +: ADDR_W];
        slot_len_d[i]   = req_len[i*8 +: 8];
        slot_size_d[i]  = req_size[i*3 +: 3];
        slot_burst_d[i] = req_burst[i*2 +: 2];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          winner_d  = win_idx;
          arvalid_d = 1'b1;
          arid_d    = ID_W'(32'(win_idx) + 32'd1);
          araddr_d  = slot_addr_q[win_idx];
          arlen_d   = slot_len_q[win_idx];
          arsize_d  = slot_size_q[win_idx];
          arburst_d = slot_burst_q[win_idx];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (arready) begin
          pending_d[winner_q] = 1'b0;
          last_grant_d        = winner_q;
          arvalid_d           = 1'b0;
          arid_d              = '0;
          araddr_d            = '0;
          arlen_d             = '0;
          arsize_d            = '0;
          arburst_d           = '0;
          state_d             = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      winner_q     <= '0;
      arvalid_q    <= 1'b0;
      arid_q       <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      arvalid_q    <= arvalid_d;
      arid_q       <= arid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
    end
  end

  // Slot payloads are qualified by pending_q, so they need no reset.
  always_ff @(posedge clock) begin
    slot_addr_q  <= slot_addr_d;
    slot_len_q   <= slot_len_d;
    slot_size_q  <= slot_size_d;
    slot_burst_q <= slot_burst_d;
  end

  assign req_ready = ~pending_q;
  assign arvalid   = arvalid_q;
  assign arid      = arid_q;
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arsize    = arsize_q;
  assign arburst   = arburst_q;
  assign busy      = (|pending_q) | arvalid_q;

endmodule
